// File: rtl/icc_rx_pkg.sv
// Shared types and constants for the ICC receive pattern checker.
// Optional error log build macro: ICC_RX_CHECKER_ERRLOG_EN.
package icc_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } rx_state_e;

  localparam logic [15:0] COMMA_DEFAULT = 16'h5cbc;
  localparam logic [1:0]  COMMA_K       = 2'b11;
  localparam int unsigned PERIOD_WORDS  = 64;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned CNT_W         = 17;
  localparam int unsigned ERRCNT_W      = 32;

  // {K flags, word} as seen on the link, used for the error log
  typedef struct packed {
    logic [1:0]        k;
    logic [WORD_W-1:0] word;
  } rx_sym_t;

endpackage

// File: rtl/icc_rx_patgen.sv
// Expected-pattern generator: 17-bit word counter with seed/advance and
// combinational expected word, K flags and end-of-period flag.
module icc_rx_patgen
  import icc_rx_pkg::*;
#(
  parameter logic [WORD_W-1:0] COMMA = COMMA_DEFAULT
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              advance,
  output logic [WORD_W-1:0] exp_word_c,
  output logic [1:0]        exp_k_c,
  output logic              period_end_c
);

  logic [CNT_W-1:0] k_q;

  // Counter: seed has priority over advance; wraps naturally at 2^17
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      k_q <= '0;
    end else if (load) begin
      k_q <= load_val;
    end else if (advance) begin
      k_q <= k_q + CNT_W'(1);
    end
  end

  // Expected symbol: comma pair at the start of each 64-word period
  always_comb begin
    exp_word_c   = k_q[CNT_W-1:1];
    exp_k_c      = 2'b00;
    period_end_c = (k_q[5:0] == 6'(PERIOD_WORDS - 1));
    if (k_q[5:1] == 5'd0) begin
      exp_word_c = COMMA;
      exp_k_c    = COMMA_K;
    end
  end

endmodule

// File: rtl/icc_rx_checker.sv
// ICC receive pattern checker: comma hunt, counter seed, period-based lock,
// error counting while locked. Define ICC_RX_CHECKER_ERRLOG_EN to add the
// first-error log outputs (err_exp, err_got, err_logged).
module icc_rx_checker
  import icc_rx_pkg::*;
#(
  parameter int unsigned       DWIDTH       = 16,
  parameter logic [15:0]       COMMA        = COMMA_DEFAULT,
  parameter int unsigned       LOCK_PERIODS = 4,
  parameter int unsigned       UNLOCK_ERRS  = 8
) (
  input  logic                clk,
  input  logic                areset_n,
  input  logic [DWIDTH-1:0]   rxdata,
  input  logic [1:0]          rxcharisk,
  input  logic                stbrxdata,
  input  logic                errclr,
  output logic [1:0]          state,
  output logic                locked,
  output logic                err_stb,
  output logic [ERRCNT_W-1:0] errcnt
`ifdef ICC_RX_CHECKER_ERRLOG_EN
  ,
  output logic [17:0]         err_exp,
  output logic [17:0]         err_got,
  output logic                err_logged
`endif
);

  localparam int unsigned PER_W = $clog2(LOCK_PERIODS + 1);
  localparam int unsigned UNL_W = $clog2(UNLOCK_ERRS + 1);

  rx_state_e             state_q, state_d;
  logic                  pair_q, pair_d;
  logic [PER_W-1:0]      period_q, period_d;
  logic [UNL_W-1:0]      unlock_q, unlock_d;
  logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d, errcnt_base;
  logic                  err_stb_q, err_stb_d;
  logic                  locked_q, locked_d;

  logic                  gen_load, gen_adv;
  logic [CNT_W-1:0]      seed_val;
  logic [WORD_W-1:0]     exp_word_c;
  logic [1:0]            exp_k_c;
  logic                  period_end_c;
  logic                  match_c, comma_c, seed_ok_c;

  icc_rx_patgen #(
    .COMMA (COMMA)
  ) u_patgen (
    .clk          (clk),
    .areset_n     (areset_n),
    .load         (gen_load),
    .load_val     (seed_val),
    .advance      (gen_adv),
    .exp_word_c   (exp_word_c),
    .exp_k_c      (exp_k_c),
    .period_end_c (period_end_c)
  );

  // Word classification against the expected symbol and the comma
  always_comb begin
    match_c   = (rxdata == exp_word_c) && (rxcharisk == exp_k_c);
    comma_c   = (rxdata == COMMA) && (rxcharisk == COMMA_K);
    seed_ok_c = (rxcharisk == 2'b00) && (rxdata[4:0] == 5'd1);
    // Seed word d came from k={d,0} or {d,1}; d[4:0]==1 pins it to {d,0}
    seed_val  = {rxdata, 1'b0} + CNT_W'(1);
  end

  // Next-state, counters and error reporting; idle cycles hold everything
  always_comb begin
    state_d     = state_q;
    pair_d      = pair_q;
    period_d    = period_q;
    unlock_d    = unlock_q;
    err_stb_d   = 1'b0;
    gen_load    = 1'b0;
    gen_adv     = 1'b0;
    errcnt_base = errclr ? '0 : errcnt_q;
    errcnt_d    = errcnt_base;

    if (stbrxdata) begin
      unique case (state_q)
        ST_HUNT: begin
          if (comma_c) begin
            if (pair_q) begin
              state_d = ST_LOAD;
              pair_d  = 1'b0;
            end else begin
              pair_d = 1'b1;
            end
          end else begin
            pair_d = 1'b0;
          end
        end
        ST_LOAD: begin
          if (seed_ok_c) begin
            gen_load = 1'b1;
            period_d = '0;
            state_d  = ST_CHECK;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_CHECK: begin
          if (match_c) begin
            gen_adv = 1'b1;
            if (period_end_c) begin
              if (period_q == PER_W'(LOCK_PERIODS - 1)) begin
                state_d  = ST_LOCKED;
                period_d = '0;
                unlock_d = '0;
              end else begin
                period_d = period_q + PER_W'(1);
              end
            end
          end else begin
            err_stb_d = 1'b1;
            state_d   = ST_HUNT;
            pair_d    = 1'b0;
            period_d  = '0;
          end
        end
        ST_LOCKED: begin
          // Counter keeps running so an isolated bad word stays local
          gen_adv = 1'b1;
          if (match_c) begin
            unlock_d = '0;
          end else begin
            err_stb_d = 1'b1;
            if (errcnt_base != '1) begin
              errcnt_d = errcnt_base + ERRCNT_W'(1);
            end
            if (unlock_q == UNL_W'(UNLOCK_ERRS - 1)) begin
              state_d  = ST_HUNT;
              unlock_d = '0;
              pair_d   = 1'b0;
            end else begin
              unlock_d = unlock_q + UNL_W'(1);
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and status registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= ST_HUNT;
      pair_q    <= 1'b0;
      period_q  <= '0;
      unlock_q  <= '0;
      errcnt_q  <= '0;
      err_stb_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      period_q  <= period_d;
      unlock_q  <= unlock_d;
      errcnt_q  <= errcnt_d;
      err_stb_q <= err_stb_d;
      locked_q  <= locked_d;
    end
  end

  assign state   = state_q;
  assign locked  = locked_q;
  assign err_stb = err_stb_q;
  assign errcnt  = errcnt_q;

`ifdef ICC_RX_CHECKER_ERRLOG_EN
  rx_sym_t exp_log_q, got_log_q;
  logic    logged_q;

  // First locked mismatch since reset/errclr is captured and held
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      exp_log_q <= '0;
      got_log_q <= '0;
      logged_q  <= 1'b0;
    end else if (err_stb_d && (state_q == ST_LOCKED) && (errclr || !logged_q)) begin
      exp_log_q <= '{k: exp_k_c, word: exp_word_c};
      got_log_q <= '{k: rxcharisk, word: rxdata};
      logged_q  <= 1'b1;
    end else if (errclr) begin
      exp_log_q <= '0;
      got_log_q <= '0;
      logged_q  <= 1'b0;
    end
  end

  assign err_exp    = exp_log_q;
  assign err_got    = got_log_q;
  assign err_logged = logged_q;
`endif

endmodule
